// File: rtl/start_banner_overlay.sv
// Start-screen overlay compositor: a static title banner and a blinking prompt banner,
// with per-frame fade-in, confirm flashing and a one-shot start request to the game FSM.
module start_banner_overlay #(
   parameter int          HRES          = 640,
   parameter int          TITLE_W       = 256,
   parameter int          TITLE_H       = 64,
   parameter int          TITLE_HSTART  = (HRES - 256) >> 1,
   parameter int          TITLE_VSTART  = 100,
   parameter int          PROMPT_W      = 128,
   parameter int          PROMPT_H      = 32,
   parameter int          PROMPT_HSTART = (HRES - 128) >> 1,
   parameter int          PROMPT_VSTART = 200,
   parameter logic [23:0] TITLE_RGB     = 24'hFFFFFF,
   parameter logic [23:0] PROMPT_RGB    = 24'hFFFF00,
   parameter int          FADE_STEP     = 8,
   parameter int          BLINK_FRAMES  = 20,
   parameter int          CONF_BLINK    = 4,
   parameter int          CONF_FRAMES   = 60
) (
   input  logic                          pixel_clk,
   input  logic                          rst_n,
   input  logic                          fsync,
   input  logic [1:0]                    game_state,
   input  logic signed [11:0]            hpos,
   input  logic signed [11:0]            vpos,
   input  logic                          ready_btn,
   output logic [$clog2(TITLE_H)-1:0]    title_addr,
   input  logic [TITLE_W-1:0]            title_bits,
   output logic [$clog2(PROMPT_H)-1:0]   prompt_addr,
   input  logic [PROMPT_W-1:0]           prompt_bits,
   output logic [2:0][7:0]               pixel,
   output logic                          use_overlay,
   output logic                          start_req,
   output logic [2:0]                    dbg_state
);

   localparam int TCW = $clog2(TITLE_W);
   localparam int PCW = $clog2(PROMPT_W);
   localparam int TAW = $clog2(TITLE_H);
   localparam int PAW = $clog2(PROMPT_H);
   localparam int CW  = 16;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FADE    = 3'd1;
   localparam logic [2:0] S_SHOW    = 3'd2;
   localparam logic [2:0] S_CONFIRM = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic signed [11:0] T_H0 = 12'(TITLE_HSTART);
   localparam logic signed [11:0] T_H1 = 12'(TITLE_HSTART + TITLE_W);
   localparam logic signed [11:0] T_V0 = 12'(TITLE_VSTART);
   localparam logic signed [11:0] T_V1 = 12'(TITLE_VSTART + TITLE_H);
   localparam logic signed [11:0] P_H0 = 12'(PROMPT_HSTART);
   localparam logic signed [11:0] P_H1 = 12'(PROMPT_HSTART + PROMPT_W);
   localparam logic signed [11:0] P_V0 = 12'(PROMPT_VSTART);
   localparam logic signed [11:0] P_V1 = 12'(PROMPT_VSTART + PROMPT_H);

   localparam logic [TCW-1:0] T_COL0 = TCW'(TITLE_HSTART);
   localparam logic [TCW-1:0] T_LAST = TCW'(TITLE_W - 1);
   localparam logic [PCW-1:0] P_COL0 = PCW'(PROMPT_HSTART);
   localparam logic [PCW-1:0] P_LAST = PCW'(PROMPT_W - 1);
   localparam logic [TAW-1:0] T_ROW0 = TAW'(TITLE_VSTART);
   localparam logic [PAW-1:0] P_ROW0 = PAW'(PROMPT_VSTART);

   logic [2:0]      state_q, state_d;
   logic [7:0]      level_q, level_d;
   logic            blink_on_q, blink_on_d;
   logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
   logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
   logic            btn_q;
   logic            start_req_q, start_req_d;
   logic            use_overlay_q;

   logic            box_t_q, box_t_d;
   logic            box_p_q, box_p_d;
   logic [TCW-1:0]  col_t_q, col_t_d;
   logic [PCW-1:0]  col_p_q, col_p_d;
   logic [2:0][7:0] pixel_q, pixel_d;

   logic            btn_rise;
   logic            leave;
   logic [8:0]      lvl_sum;
   logic [CW-1:0]   blink_nxt;
   logic [CW-1:0]   frame_nxt;

   // Output scaling: channel * (level+1) / 256, exact at level 255 and zero at level 0.
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [8:0] l);
      logic [15:0] p;
      p = {8'd0, c} * {7'd0, l};
      return 8'(p >> 8);
   endfunction

   assign btn_rise  = ready_btn & ~btn_q;
   assign leave     = (state_q != S_IDLE) && (game_state != 2'd0);
   assign lvl_sum   = {1'b0, level_q} + 9'(FADE_STEP);
   assign blink_nxt = blink_cnt_q + CW'(1);
   assign frame_nxt = frame_cnt_q + CW'(1);

   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      blink_on_d  = blink_on_q;
      blink_cnt_d = blink_cnt_q;
      frame_cnt_d = frame_cnt_q;
      start_req_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (game_state == 2'd0) begin
               state_d = S_FADE;
               level_d = 8'd0;
            end
         end
         S_FADE: begin
            if (fsync) begin
               if (lvl_sum >= 9'd255) begin
                  level_d     = 8'd255;
                  state_d     = S_SHOW;
                  blink_on_d  = 1'b1;
                  blink_cnt_d = '0;
               end else begin
                  level_d = lvl_sum[7:0];
               end
            end
         end
         S_SHOW: begin
            // A button edge takes the same cycle's fsync with it.
            if (btn_rise) begin
               state_d     = S_CONFIRM;
               blink_on_d  = 1'b1;
               blink_cnt_d = '0;
               frame_cnt_d = '0;
            end else if (fsync) begin
               if (blink_nxt == CW'(BLINK_FRAMES)) begin
                  blink_cnt_d = '0;
                  blink_on_d  = ~blink_on_q;
               end else begin
                  blink_cnt_d = blink_nxt;
               end
            end
         end
         S_CONFIRM: begin
            if (fsync) begin
               if (frame_nxt == CW'(CONF_FRAMES)) begin
                  state_d     = S_DONE;
                  start_req_d = 1'b1;
                  blink_on_d  = 1'b1;
                  blink_cnt_d = '0;
                  frame_cnt_d = '0;
               end else begin
                  frame_cnt_d = frame_nxt;
                  if (blink_nxt == CW'(CONF_BLINK)) begin
                     blink_cnt_d = '0;
                     blink_on_d  = ~blink_on_q;
                  end else begin
                     blink_cnt_d = blink_nxt;
                  end
               end
            end
         end
         S_DONE: begin
            blink_on_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            level_d = 8'd0;
         end
      endcase
      if (leave) begin
         state_d     = S_IDLE;
         level_d     = 8'd0;
         blink_on_d  = 1'b1;
         blink_cnt_d = '0;
         frame_cnt_d = '0;
         start_req_d = 1'b0;
      end
   end

   // S0: ROM row addresses go out combinationally; box tests and columns are registered
   // so they line up with the ROM data one cycle later.
   always_comb begin
      title_addr  = vpos[TAW-1:0] - T_ROW0;
      prompt_addr = vpos[PAW-1:0] - P_ROW0;
      box_t_d     = (vpos >= T_V0) && (vpos < T_V1) && (hpos >= T_H0) && (hpos < T_H1);
      box_p_d     = (vpos >= P_V0) && (vpos < P_V1) && (hpos >= P_H0) && (hpos < P_H1);
      col_t_d     = hpos[TCW-1:0] - T_COL0;
      col_p_d     = hpos[PCW-1:0] - P_COL0;
   end

   logic        hit_t, hit_p, show_prompt;
   logic [23:0] rgb;
   logic [8:0]  lvl_p1;

   always_comb begin
      show_prompt = (state_q == S_SHOW) || (state_q == S_CONFIRM) || (state_q == S_DONE);
      hit_t       = box_t_q & title_bits[T_LAST - col_t_q];
      hit_p       = box_p_q & prompt_bits[P_LAST - col_p_q] & blink_on_q & show_prompt;
      rgb         = 24'd0;
      if (state_q != S_IDLE) begin
         if (hit_t) begin
            rgb = TITLE_RGB;
         end else if (hit_p) begin
            rgb = PROMPT_RGB;
         end
      end
      lvl_p1     = {1'b0, level_q} + 9'd1;
      pixel_d[2] = scale(rgb[23:16], lvl_p1);
      pixel_d[1] = scale(rgb[15:8],  lvl_p1);
      pixel_d[0] = scale(rgb[7:0],   lvl_p1);
   end

   always_ff @(posedge pixel_clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         level_q       <= 8'd0;
         blink_on_q    <= 1'b1;
         blink_cnt_q   <= '0;
         frame_cnt_q   <= '0;
         btn_q         <= 1'b0;
         start_req_q   <= 1'b0;
         use_overlay_q <= 1'b0;
         box_t_q       <= 1'b0;
         box_p_q       <= 1'b0;
         col_t_q       <= '0;
         col_p_q       <= '0;
         pixel_q       <= '0;
      end else begin
         state_q       <= state_d;
         level_q       <= level_d;
         blink_on_q    <= blink_on_d;
         blink_cnt_q   <= blink_cnt_d;
         frame_cnt_q   <= frame_cnt_d;
         btn_q         <= ready_btn;
         start_req_q   <= start_req_d;
         use_overlay_q <= (state_q != S_IDLE);
         box_t_q       <= box_t_d;
         box_p_q       <= box_p_d;
         col_t_q       <= col_t_d;
         col_p_q       <= col_p_d;
         pixel_q       <= pixel_d;
      end
   end

   assign pixel       = pixel_q;
   assign use_overlay = use_overlay_q;
   assign start_req   = start_req_q;
   assign dbg_state   = state_q;

endmodule
